// File: rtl/int_sequencer_if.sv
// Interrupt-entry bus between the CPU pipeline/memory port B and int_sequencer.
// dbg_state mirrors the sequencer FSM state for observation.
interface int_sequencer_if;
   logic       intr_sig;
   logic       instr_boundary;
   logic       rti_exec;
   logic [7:0] ret_pc;
   logic [7:0] mem_rdata;
   logic       pc_hold;
   logic       if_id_hold;
   logic       inject_bubble;
   logic       push_req;
   logic [7:0] push_data;
   logic       vec_rd;
   logic [7:0] mem_addr;
   logic       pc_load;
   logic [7:0] pc_load_val;
   logic       in_service;
   logic [2:0] dbg_state;

   // push_req and vec_rd are one-cycle strobes with no ready: the MEM stage and
   // port B accept them unconditionally in the cycle they are high.
   modport master (
      output intr_sig, instr_boundary, rti_exec, ret_pc, mem_rdata,
      input  pc_hold, if_id_hold, inject_bubble, push_req, push_data,
             vec_rd, mem_addr, pc_load, pc_load_val, in_service, dbg_state
   );

   modport slave (
      input  intr_sig, instr_boundary, rti_exec, ret_pc, mem_rdata,
      output pc_hold, if_id_hold, inject_bubble, push_req, push_data,
             vec_rd, mem_addr, pc_load, pc_load_val, in_service, dbg_state
   );
endinterface

// File: rtl/int_sequencer.sv
// Hardware-interrupt entry sequencer: edge latch, drain, push return PC, fetch vector, load PC.
// Optional INT_SYNC_EN adds a 2-flop synchronizer on intr_sig ahead of the edge detector.
module int_sequencer #(
   parameter logic [7:0] VEC_ADDR     = 8'h01,
   parameter int         DRAIN_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rstn,
   int_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_PUSH   = 3'd2,
      S_VFETCH = 3'd3,
      S_VLOAD  = 3'd4
   } state_t;

   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_pending;
   logic       r_in_service;
   logic       r_intr_prev;
   logic [2:0] r_drain_cnt;
   logic [7:0] r_ret_q;
   logic [7:0] r_vec_q;
   logic       w_intr_s;
   logic       w_rise;
   logic       w_start;

   logic       w_pc_hold;
   logic       w_if_id_hold;
   logic       w_inject_bubble;
   logic       w_push_req;
   logic [7:0] w_push_data;
   logic       w_vec_rd;
   logic [7:0] w_mem_addr;
   logic       w_pc_load;
   logic [7:0] w_pc_load_val;

`ifdef INT_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= bus.intr_sig;
         r_sync2 <= r_sync1;
      end
   end

   assign w_intr_s = r_sync2;
`else
   assign w_intr_s = bus.intr_sig;
`endif

   assign w_rise  = w_intr_s & ~r_intr_prev;
   // instr_boundary only matters here; once DRAIN starts the sequence runs to completion.
   assign w_start = (r_state == S_IDLE) & r_pending & ~r_in_service & bus.instr_boundary;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_state_nxt = S_DRAIN;
         S_DRAIN:  if (r_drain_cnt == 3'd0) w_state_nxt = S_PUSH;
         S_PUSH:   w_state_nxt = S_VFETCH;
         S_VFETCH: w_state_nxt = S_VLOAD;
         S_VLOAD:  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_intr_prev  <= 1'b0;
         r_pending    <= 1'b0;
         r_in_service <= 1'b0;
         r_drain_cnt  <= 3'd0;
         r_ret_q      <= 8'h00;
         r_vec_q      <= 8'h00;
      end else begin
         r_intr_prev <= w_intr_s;
         // A new edge wins over the entry-taken clear so it is never dropped.
         if (w_rise)                  r_pending <= 1'b1;
         else if (r_state == S_VLOAD) r_pending <= 1'b0;
         if (r_state == S_VLOAD)      r_in_service <= 1'b1;
         else if (bus.rti_exec)       r_in_service <= 1'b0;
         if (w_start) begin
            r_ret_q     <= bus.ret_pc;
            r_drain_cnt <= DRAIN_INIT;
         end else if (r_state == S_DRAIN && r_drain_cnt != 3'd0) begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
         end
         if (r_state == S_VFETCH) r_vec_q <= bus.mem_rdata;
      end
   end

   always_comb begin
      w_pc_hold       = 1'b0;
      w_if_id_hold    = 1'b0;
      w_inject_bubble = 1'b0;
      w_push_req      = 1'b0;
      w_push_data     = 8'h00;
      w_vec_rd        = 1'b0;
      w_mem_addr      = 8'h00;
      w_pc_load       = 1'b0;
      w_pc_load_val   = 8'h00;
      case (r_state)
         S_DRAIN: begin
            w_pc_hold       = 1'b1;
            w_if_id_hold    = 1'b1;
            w_inject_bubble = 1'b1;
         end
         S_PUSH: begin
            w_pc_hold       = 1'b1;
            w_if_id_hold    = 1'b1;
            w_inject_bubble = 1'b1;
            w_push_req      = 1'b1;
            w_push_data     = r_ret_q;
         end
         S_VFETCH: begin
            w_pc_hold       = 1'b1;
            w_if_id_hold    = 1'b1;
            w_inject_bubble = 1'b1;
            w_vec_rd        = 1'b1;
            w_mem_addr      = VEC_ADDR;
         end
         S_VLOAD: begin
            // IF/ID is released so the bubble flushes the wrong-path fetch.
            w_inject_bubble = 1'b1;
            w_pc_load       = 1'b1;
            w_pc_load_val   = r_vec_q;
         end
         default: ;
      endcase
   end

   assign bus.pc_hold       = w_pc_hold;
   assign bus.if_id_hold    = w_if_id_hold;
   assign bus.inject_bubble = w_inject_bubble;
   assign bus.push_req      = w_push_req;
   assign bus.push_data     = w_push_data;
   assign bus.vec_rd        = w_vec_rd;
   assign bus.mem_addr      = w_mem_addr;
   assign bus.pc_load       = w_pc_load;
   assign bus.pc_load_val   = w_pc_load_val;
   assign bus.in_service    = r_in_service;
   assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: entry timing, boundary wait, no nesting, merge, reset abort.
// Expected latencies adjust for the INT_SYNC_EN build.
module tb_int_sequencer;
   localparam int D = 2;
`ifdef INT_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   int_sequencer_if bus ();

   int_sequencer #(
      .VEC_ADDR     (8'h01),
      .DRAIN_CYCLES (D)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   logic [7:0] mem [0:255];
   assign bus.mem_rdata = mem[bus.mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   int         n_push = 0;
   int         n_load = 0;
   int         push_cyc = 0;
   int         load_cyc = 0;
   logic [7:0] push_data_seen = 8'h00;
   logic [7:0] load_val_seen  = 8'h00;
   logic [7:0] vec_addr_seen  = 8'h00;
   logic [2:0] push_ctl = 3'b000;
   logic [2:0] load_ctl = 3'b000;
   logic       overlap  = 1'b0;
   logic       bus_viol = 1'b0;

   always @(negedge clk) begin
      if (bus.push_req) begin
         n_push++;
         push_cyc       = cyc;
         push_data_seen = bus.push_data;
         push_ctl       = {bus.pc_hold, bus.if_id_hold, bus.inject_bubble};
      end
      if (bus.vec_rd) vec_addr_seen = bus.mem_addr;
      if (bus.pc_load) begin
         n_load++;
         load_cyc      = cyc;
         load_val_seen = bus.pc_load_val;
         load_ctl      = {bus.pc_hold, bus.if_id_hold, bus.inject_bubble};
      end
      if (bus.push_req && bus.vec_rd) overlap = 1'b1;
      if ((!bus.push_req && bus.push_data != 8'h00) ||
          (!bus.vec_rd && bus.mem_addr != 8'h00)) bus_viol = 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] out_vec();
      return {1'b0, bus.pc_hold, bus.if_id_hold, bus.inject_bubble, bus.push_req,
              bus.push_data, bus.vec_rd, bus.mem_addr, bus.pc_load, bus.pc_load_val,
              bus.in_service};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_intr();
      bus.intr_sig = 1'b1;
      tick();
      bus.intr_sig = 1'b0;
      tick();
   endtask

   task automatic pulse_rti();
      bus.rti_exec = 1'b1;
      tick();
      bus.rti_exec = 1'b0;
   endtask

   task automatic wait_load(input string tag, input int budget);
      int  start;
      bit  got;
      start = n_load;
      got   = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_load != start) begin
            got = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(got), 32'd1);
   endtask

   initial begin
      int t0;
      int np;
      int nl;
      bit reached;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[1] = 8'h80;

      rstn               = 1'b0;
      bus.intr_sig       = 1'b0;
      bus.instr_boundary = 1'b1;
      bus.rti_exec       = 1'b0;
      bus.ret_pc         = 8'h00;
      tick();
      tick();
      check_eq("reset_outputs", out_vec(), 32'd0);
      check_eq("reset_state", 32'(bus.dbg_state), 32'd0);
      rstn = 1'b1;
      tick();
      tick();

      // basic entry
      bus.ret_pc = 8'h2A;
      t0 = cyc;
      bus.intr_sig = 1'b1;
      tick();
      bus.intr_sig = 1'b0;
      wait_load("t2_load_seen", 40);
      check_eq("t2_push_lat", 32'(push_cyc - t0 - 1), 32'(D + 1 + SYNC));
      check_eq("t2_push_data", 32'(push_data_seen), 32'h2A);
      check_eq("t2_load_lat", 32'(load_cyc - t0 - 1), 32'(D + 3 + SYNC));
      check_eq("t2_load_val", 32'(load_val_seen), 32'h80);
      check_eq("t2_in_service", 32'(bus.in_service), 32'd1);
      check_eq("t2_state_idle", 32'(bus.dbg_state), 32'd0);
      check_eq("t2_push_ctl", 32'(push_ctl), 32'b111);
      check_eq("t2_load_ctl", 32'(load_ctl), 32'b001);
      check_eq("t2_vec_addr", 32'(vec_addr_seen), 32'h01);

      // no nesting, then re-entry after RTI
      np = n_push;
      pulse_intr();
      for (int i = 0; i < 10; i++) tick();
      check_eq("t4_no_nest_push", 32'(n_push), 32'(np));
      check_eq("t4_no_nest_state", 32'(bus.dbg_state), 32'd0);
      check_eq("t4_still_service", 32'(bus.in_service), 32'd1);
      bus.ret_pc = 8'h3C;
      t0 = cyc;
      pulse_rti();
      check_eq("t4_service_clr", 32'(bus.in_service), 32'd0);
      wait_load("t4_load_seen", 40);
      check_eq("t4_load_lat", 32'(load_cyc - t0 - 1), 32'(D + 3));
      check_eq("t4_push_data", 32'(push_data_seen), 32'h3C);
      check_eq("t4_load_val", 32'(load_val_seen), 32'h80);

      // boundary wait shifts latency by exactly 4
      pulse_rti();
      tick();
      tick();
      bus.ret_pc = 8'h51;
      np = n_push;
      t0 = cyc;
      bus.instr_boundary = 1'b0;
      bus.intr_sig = 1'b1;
      tick();
      bus.intr_sig = 1'b0;
      for (int i = 0; i < 4 + SYNC; i++) tick();
      check_eq("t3_wait_state", 32'(bus.dbg_state), 32'd0);
      check_eq("t3_wait_push", 32'(n_push), 32'(np));
      bus.instr_boundary = 1'b1;
      wait_load("t3_load_seen", 40);
      check_eq("t3_push_lat", 32'(push_cyc - t0 - 1), 32'(D + 1 + 4 + SYNC));
      check_eq("t3_load_lat", 32'(load_cyc - t0 - 1), 32'(D + 3 + 4 + SYNC));
      check_eq("t3_push_data", 32'(push_data_seen), 32'h51);

      // three edges while in service merge into one entry after RTI
      np = n_push;
      nl = n_load;
      pulse_intr();
      pulse_intr();
      pulse_intr();
      for (int i = 0; i < 5; i++) tick();
      check_eq("t5_held_push", 32'(n_push), 32'(np));
      pulse_rti();
      for (int i = 0; i < 40; i++) tick();
      check_eq("t5_one_load", 32'(n_load), 32'(nl + 1));
      check_eq("t5_one_push", 32'(n_push), 32'(np + 1));

      // reset in the middle of PUSH aborts the entry
      pulse_rti();
      tick();
      tick();
      nl = n_load;
      bus.intr_sig = 1'b1;
      tick();
      bus.intr_sig = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.dbg_state == 3'd2) begin
            reached = 1'b1;
            break;
         end
         tick();
      end
      check_eq("t1_reach_push", 32'(reached), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("t1_outputs_zero", out_vec(), 32'd0);
      check_eq("t1_state_idle", 32'(bus.dbg_state), 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check_eq("t1_no_load", 32'(n_load), 32'(nl));
      check_eq("t1_idle_after", out_vec(), 32'd0);

      check_eq("port_b_not_shared", 32'(overlap), 32'd0);
      check_eq("bus_zero_when_idle", 32'(bus_viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
